// File: rtl/blink_core.sv
// LED blink engine: shadowed period/duty/count, continuous or counted mode, registered LED drive.
// Outputs change on the same edge as the state register. There is no backpressure; ctrl_wr is always accepted.
module blink_core #(
  parameter int NUM_LEDS           = 4,
  parameter int C_S_AXI_DATA_WIDTH = 32
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] ctrl_reg,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] period_reg,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] duty_reg,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] count_reg,
  input  logic                          ctrl_wr,
  output logic [NUM_LEDS-1:0]           led_out,
  output logic                          busy,
  output logic                          done,
  output logic [C_S_AXI_DATA_WIDTH-1:0] blink_cnt
);

  localparam int DW = C_S_AXI_DATA_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [DW-1:0]         period_q, period_d;
  logic [DW-1:0]         duty_q, duty_d;
  logic [DW-1:0]         count_q, count_d;
  logic [DW-1:0]         phase_q, phase_d;
  logic [DW-1:0]         cnt_q, cnt_d;
  logic                  mode_q, mode_d;
  logic                  invert_q, invert_d;
  logic [NUM_LEDS-1:0]   mask_q, mask_d;
  logic [NUM_LEDS-1:0]   led_q, led_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  start, abort, wrap;
  logic [DW-1:0]         cnt_inc, phase_inc;
  logic                  unused_ok;

  assign unused_ok = ^ctrl_reg;

  assign start     = ctrl_wr && ctrl_reg[0];
  assign abort     = ctrl_wr && !ctrl_reg[0];
  assign wrap      = (phase_q == period_q - DW'(1));
  assign phase_inc = phase_q + DW'(1);
  assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + DW'(1);

  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    duty_d   = duty_q;
    count_d  = count_q;
    phase_d  = phase_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    invert_d = invert_q;
    mask_d   = mask_q;
    done_d   = done_q;

    if (start) begin
      period_d = (period_reg < DW'(2)) ? DW'(2) : period_reg;
      duty_d   = duty_reg;
      count_d  = count_reg;
      mode_d   = ctrl_reg[1];
      invert_d = ctrl_reg[2];
      mask_d   = ctrl_reg[4 +: NUM_LEDS];
      phase_d  = '0;
      cnt_d    = '0;
      done_d   = 1'b0;
      // A counted run of zero blinks completes without ever lighting.
      if (ctrl_reg[1] && (count_reg == '0)) begin
        state_d = S_DONE;
        done_d  = 1'b1;
      end else begin
        state_d = (duty_reg != '0) ? S_ON : S_OFF;
      end
    end else if (abort) begin
      state_d = S_IDLE;
    end else if ((state_q == S_ON) || (state_q == S_OFF)) begin
      if (wrap) begin
        phase_d = '0;
        cnt_d   = cnt_inc;
        if (mode_q && (cnt_inc == count_q)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = (duty_q != '0) ? S_ON : S_OFF;
        end
      end else begin
        phase_d = phase_inc;
        state_d = (phase_inc < duty_q) ? S_ON : S_OFF;
      end
    end

    // LED and busy are computed from the next state so they track it with no lag.
    busy_d = (state_d == S_ON) || (state_d == S_OFF);
    led_d  = ((state_d == S_ON) ? mask_d : '0) ^ {NUM_LEDS{invert_d}};
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q  <= S_IDLE;
      period_q <= '0;
      duty_q   <= '0;
      count_q  <= '0;
      phase_q  <= '0;
      cnt_q    <= '0;
      mode_q   <= 1'b0;
      invert_q <= 1'b0;
      mask_q   <= '0;
      led_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      duty_q   <= duty_d;
      count_q  <= count_d;
      phase_q  <= phase_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      invert_q <= invert_d;
      mask_q   <= mask_d;
      led_q    <= led_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign led_out   = led_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign blink_cnt = cnt_q;

endmodule
